axi4_burst_splitter: RTL

- Converts one linear write/read transfer request (start address, beat count) into a sequence of AXI4-legal INCR address-channel bursts.
- Each burst is at most 256 beats and never crosses a 4 KB boundary.
- Sits directly upstream of the AXI4 address channel (AW or AR) of a master port; its bursts are what the AXI4 agent and monitor consume.
- Burst size is always the full bus width.

---
 rtl/axi4_burst_splitter_pkg.sv | 41 ++++
 rtl/axi4_burst_len_calc.sv | 41 ++++
 rtl/axi4_burst_splitter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_splitter_pkg.sv
// Shared AXI4 address-channel constants, size encoding and splitter FSM states.
// Used by axi4_burst_splitter and axi4_burst_len_calc.
package axi4_burst_splitter_pkg;

   localparam int AXI4_MAX_BURST_LEN = 256;
   localparam int AXI4_4K_BYTES      = 4096;

   localparam logic [1:0] AXI4_BURST_INCR = 2'b01;

   typedef enum logic [2:0] {
      AXI4_SIZE_1B   = 3'd0,
      AXI4_SIZE_2B   = 3'd1,
      AXI4_SIZE_4B   = 3'd2,
      AXI4_SIZE_8B   = 3'd3,
      AXI4_SIZE_16B  = 3'd4,
      AXI4_SIZE_32B  = 3'd5,
      AXI4_SIZE_64B  = 3'd6,
      AXI4_SIZE_128B = 3'd7
   } axi4_size_e;

   function automatic axi4_size_e axi4_bytes_to_size(input int bytes);
      case (bytes)
         2:       return AXI4_SIZE_2B;
         4:       return AXI4_SIZE_4B;
         8:       return AXI4_SIZE_8B;
         16:      return AXI4_SIZE_16B;
         32:      return AXI4_SIZE_32B;
         64:      return AXI4_SIZE_64B;
         128:     return AXI4_SIZE_128B;
         default: return AXI4_SIZE_1B;
      endcase
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_FIN   = 2'd3
   } splitter_state_e;

endpackage

// File: rtl/axi4_burst_len_calc.sv
// Combinational length of the next INCR burst: min(remaining, 256, beats to the
// next 4 KB boundary), plus a flag saying the 4 KB term was the limiting one.
module axi4_burst_len_calc
   import axi4_burst_splitter_pkg::*;
#(
   parameter int DATA_WIDTH_P  = 64,
   parameter int BEATS_WIDTH_P = 24
) (
   input  logic [11:0]              cur_addr_lo,
   input  logic [BEATS_WIDTH_P-1:0] remaining,
   output logic [8:0]               n,
   output logic                     limited_4k
);

   localparam int SIZE_LOG2 = int'(axi4_bytes_to_size(DATA_WIDTH_P / 8));

   logic [12:0] bytes_to_4k;
   logic [12:0] beats_to_4k;
   logic [8:0]  cap;

   always_comb begin
      // 13-bit subtraction so an address on a boundary yields a full 4096 bytes
      bytes_to_4k = 13'(AXI4_4K_BYTES) - {1'b0, cur_addr_lo};
      beats_to_4k = bytes_to_4k >> SIZE_LOG2;

      if (remaining > BEATS_WIDTH_P'(AXI4_MAX_BURST_LEN)) begin
         cap = 9'(AXI4_MAX_BURST_LEN);
      end else begin
         cap = remaining[8:0];
      end

      if ({4'b0000, cap} > beats_to_4k) begin
         n          = beats_to_4k[8:0];
         limited_4k = 1'b1;
      end else begin
         n          = cap;
         limited_4k = 1'b0;
      end
   end

endmodule

// File: rtl/axi4_burst_splitter.sv
// Splits a linear (addr, beats) request into AXI4 INCR bursts of <=256 beats that
// never cross 4 KB. Optional statistics counters: AXI4_BURST_SPLITTER_STATS_EN.
module axi4_burst_splitter
   import axi4_burst_splitter_pkg::*;
#(
   parameter int ID_WIDTH_P    = 4,
   parameter int ADDR_WIDTH_P  = 32,
   parameter int DATA_WIDTH_P  = 64,
   parameter int BEATS_WIDTH_P = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ID_WIDTH_P-1:0]    req_id,
   input  logic [ADDR_WIDTH_P-1:0]  req_addr,
   input  logic [BEATS_WIDTH_P-1:0] req_beats,
   output logic [ID_WIDTH_P-1:0]    axid,
   output logic [ADDR_WIDTH_P-1:0]  axaddr,
   output logic [7:0]               axlen,
   output logic [2:0]               axsize,
   output logic [1:0]               axburst,
   output logic                     axvalid,
   input  logic                     axready,
`ifdef AXI4_BURST_SPLITTER_STATS_EN
   output logic [15:0]              sr_burst_count,
   output logic [15:0]              sr_split_4k_count,
`endif
   output logic                     done
);

   localparam int SIZE_LOG2 = int'(axi4_bytes_to_size(DATA_WIDTH_P / 8));
   localparam logic [2:0] AXSIZE_C = 3'(axi4_bytes_to_size(DATA_WIDTH_P / 8));
   localparam logic [ADDR_WIDTH_P-1:0] ADDR_ALIGN_MASK = {ADDR_WIDTH_P{1'b1}} << SIZE_LOG2;

   splitter_state_e          state_q, state_d;
   logic                     req_ready_q, req_ready_d;
   logic                     done_q, done_d;
   logic                     axvalid_q, axvalid_d;
   logic [ID_WIDTH_P-1:0]    axid_q, axid_d;
   logic [ADDR_WIDTH_P-1:0]  axaddr_q, axaddr_d;
   logic [7:0]               axlen_q, axlen_d;
   logic [ADDR_WIDTH_P-1:0]  cur_addr_q, cur_addr_d;
   logic [BEATS_WIDTH_P-1:0] remaining_q, remaining_d;

   logic [8:0] burst_n;
   logic       burst_limited_4k;
   logic       req_hs;
   logic       ax_hs;

   axi4_burst_len_calc #(
      .DATA_WIDTH_P  (DATA_WIDTH_P),
      .BEATS_WIDTH_P (BEATS_WIDTH_P)
   ) u_len_calc (
      .cur_addr_lo (cur_addr_q[11:0]),
      .remaining   (remaining_q),
      .n           (burst_n),
      .limited_4k  (burst_limited_4k)
   );

   assign req_hs = (state_q == ST_IDLE) && req_valid && req_ready_q;
   assign ax_hs  = (state_q == ST_ISSUE) && axvalid_q && axready;

   always_comb begin
      state_d     = state_q;
      req_ready_d = 1'b0;
      done_d      = 1'b0;
      axvalid_d   = axvalid_q;
      axid_d      = axid_q;
      axaddr_d    = axaddr_q;
      axlen_d     = axlen_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;

      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (req_hs) begin
               req_ready_d = 1'b0;
               axid_d      = req_id;
               cur_addr_d  = req_addr & ADDR_ALIGN_MASK;
               remaining_d = req_beats;
               state_d     = (req_beats != '0) ? ST_CALC : ST_FIN;
            end
         end
         ST_CALC: begin
            axaddr_d    = cur_addr_q;
            axlen_d     = 8'(burst_n - 9'd1);
            axvalid_d   = 1'b1;
            cur_addr_d  = cur_addr_q + (ADDR_WIDTH_P'(burst_n) << SIZE_LOG2);
            remaining_d = remaining_q - BEATS_WIDTH_P'(burst_n);
            state_d     = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (ax_hs) begin
               axvalid_d = 1'b0;
               state_d   = (remaining_q != '0) ? ST_CALC : ST_FIN;
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b0;
         done_q      <= 1'b0;
         axvalid_q   <= 1'b0;
         axid_q      <= '0;
         axaddr_q    <= '0;
         axlen_q     <= '0;
         cur_addr_q  <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         done_q      <= done_d;
         axvalid_q   <= axvalid_d;
         axid_q      <= axid_d;
         axaddr_q    <= axaddr_d;
         axlen_q     <= axlen_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
      end
   end

`ifdef AXI4_BURST_SPLITTER_STATS_EN
   logic [15:0] sr_burst_count_q, sr_burst_count_d;
   logic [15:0] sr_split_4k_count_q, sr_split_4k_count_d;

   // Split count is taken when the burst length is decided, not at handshake
   always_comb begin
      sr_burst_count_d    = sr_burst_count_q;
      sr_split_4k_count_d = sr_split_4k_count_q;
      if (ax_hs && (sr_burst_count_q != 16'hFFFF)) begin
         sr_burst_count_d = sr_burst_count_q + 16'd1;
      end
      if ((state_q == ST_CALC) && burst_limited_4k && (sr_split_4k_count_q != 16'hFFFF)) begin
         sr_split_4k_count_d = sr_split_4k_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_burst_count_q    <= '0;
         sr_split_4k_count_q <= '0;
      end else begin
         sr_burst_count_q    <= sr_burst_count_d;
         sr_split_4k_count_q <= sr_split_4k_count_d;
      end
   end

   assign sr_burst_count    = sr_burst_count_q;
   assign sr_split_4k_count = sr_split_4k_count_q;
`else
   logic unused_limited_4k;
   assign unused_limited_4k = burst_limited_4k;
`endif

   assign req_ready = req_ready_q;
   assign done      = done_q;
   assign axvalid   = axvalid_q;
   assign axid      = axid_q;
   assign axaddr    = axaddr_q;
   assign axlen     = axlen_q;
   assign axsize    = AXSIZE_C;
   assign axburst   = AXI4_BURST_INCR;

endmodule
